// File: rtl/minicpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : minicpu_mc
// Purpose  : Multi-cycle LoongArch32 integer-subset core. Each instruction
//            walks BOOT/IF/EX/MEM/WB over req/ack instruction and data ports
//            that may insert any number of wait states. Supported:
//            add.w, sub.w, addi.w, ld.w, st.w, beq, bne, b, bl.
//            Undecoded words retire as NOPs, or halt the core when
//            TRAP_ON_ILLEGAL=1.
// Ports    : clk, resetn          - clock, async active-low reset
//            inst_req/addr/ack/rdata - instruction fetch handshake
//            data_req/we/addr/wdata/ack/rdata - data access handshake
//            halted              - core stopped on an illegal instruction
//            debug_wb_*          - writeback trace, valid in the WB cycle
// Revision : 1.0 - initial release
// ============================================================================
module minicpu_mc #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        halted,
  output logic        debug_wb_valid,
  output logic [31:0] debug_wb_pc,
  output logic        debug_wb_we,
  output logic [4:0]  debug_wb_rnum,
  output logic [31:0] debug_wb_wdata
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IF   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_next_pc;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rnum;
  logic        r_wb_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;
  logic        r_is_load;

  // Register file is deliberately left without reset; r0 is never written
  // and is forced to zero on every read.
  logic [31:0] r_rf [0:31];

  // ---------------- decode ----------------
  logic [4:0]  w_rd;
  logic [4:0]  w_rj;
  logic [4:0]  w_rk;
  logic        w_is_add;
  logic        w_is_sub;
  logic        w_is_addi;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_beq;
  logic        w_is_bne;
  logic        w_is_b;
  logic        w_is_bl;
  logic [31:0] w_si12;
  logic [31:0] w_br_off;
  logic [31:0] w_jmp_off;
  logic [4:0]  w_rb_addr;
  logic [31:0] w_ra;
  logic [31:0] w_rb;
  logic [31:0] w_pc4;
  logic [31:0] w_mem_addr;

  assign w_rd      = r_ir[4:0];
  assign w_rj      = r_ir[9:5];
  assign w_rk      = r_ir[14:10];
  assign w_is_add  = (r_ir[31:15] == 17'h00020);
  assign w_is_sub  = (r_ir[31:15] == 17'h00022);
  assign w_is_addi = (r_ir[31:22] == 10'h00a);
  assign w_is_ld   = (r_ir[31:22] == 10'h0a2);
  assign w_is_st   = (r_ir[31:22] == 10'h0a6);
  assign w_is_beq  = (r_ir[31:26] == 6'h16);
  assign w_is_bne  = (r_ir[31:26] == 6'h17);
  assign w_is_b    = (r_ir[31:26] == 6'h14);
  assign w_is_bl   = (r_ir[31:26] == 6'h15);

  assign w_si12    = {{20{r_ir[21]}}, r_ir[21:10]};
  assign w_br_off  = {{14{r_ir[25]}}, r_ir[25:10], 2'b00};
  assign w_jmp_off = {{4{r_ir[9]}}, r_ir[9:0], r_ir[25:10], 2'b00};

  // Stores and conditional branches use rd as their second source operand.
  assign w_rb_addr  = (w_is_st || w_is_beq || w_is_bne) ? w_rd : w_rk;
  assign w_ra       = (w_rj == 5'd0) ? 32'd0 : r_rf[w_rj];
  assign w_rb       = (w_rb_addr == 5'd0) ? 32'd0 : r_rf[w_rb_addr];
  assign w_pc4      = r_pc + 32'd4;
  assign w_mem_addr = w_ra + w_si12;

  logic [31:0] w_ex_val;
  logic        w_ex_we;
  logic [4:0]  w_ex_rnum;
  logic [31:0] w_ex_npc;
  logic        w_illegal;

  always_comb begin
    w_ex_val  = 32'd0;
    w_ex_we   = 1'b0;
    w_ex_rnum = w_rd;
    w_ex_npc  = w_pc4;
    w_illegal = 1'b0;
    if (w_is_add) begin
      w_ex_val = w_ra + w_rb;
      w_ex_we  = 1'b1;
    end else if (w_is_sub) begin
      w_ex_val = w_ra - w_rb;
      w_ex_we  = 1'b1;
    end else if (w_is_addi) begin
      w_ex_val = w_ra + w_si12;
      w_ex_we  = 1'b1;
    end else if (w_is_ld || w_is_st) begin
      // For loads this value is overwritten by the returned data on ack.
      w_ex_val = w_mem_addr;
      w_ex_we  = w_is_ld;
    end else if (w_is_beq) begin
      if (w_ra == w_rb) w_ex_npc = r_pc + w_br_off;
    end else if (w_is_bne) begin
      if (w_ra != w_rb) w_ex_npc = r_pc + w_br_off;
    end else if (w_is_b) begin
      w_ex_npc = r_pc + w_jmp_off;
    end else if (w_is_bl) begin
      w_ex_npc  = r_pc + w_jmp_off;
      w_ex_val  = w_pc4;
      w_ex_we   = 1'b1;
      w_ex_rnum = 5'd1;
    end else begin
      w_illegal = 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT: w_state_nxt = S_IF;
      S_IF:   if (inst_ack) w_state_nxt = S_EX;
      S_EX: begin
        if (w_is_ld || w_is_st)               w_state_nxt = S_MEM;
        else if (w_illegal && TRAP_ON_ILLEGAL) w_state_nxt = S_HALT;
        else                                   w_state_nxt = S_WB;
      end
      S_MEM:  if (data_ack) w_state_nxt = S_WB;
      S_WB:   w_state_nxt = S_IF;
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_ir        <= 32'd0;
      r_next_pc   <= 32'd0;
      r_wb_data   <= 32'd0;
      r_wb_rnum   <= 5'd0;
      r_wb_we     <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_we    <= 1'b0;
      r_is_load   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IF: if (inst_ack) r_ir <= inst_rdata;
        S_EX: begin
          r_next_pc   <= w_ex_npc;
          r_wb_data   <= w_ex_val;
          r_wb_rnum   <= w_ex_rnum;
          r_wb_we     <= w_ex_we && (w_ex_rnum != 5'd0);
          r_mem_addr  <= w_mem_addr;
          r_mem_wdata <= w_rb;
          r_mem_we    <= w_is_st;
          r_is_load   <= w_is_ld;
        end
        S_MEM: if (data_ack && r_is_load) r_wb_data <= data_rdata;
        S_WB:  r_pc <= r_next_pc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_WB) && r_wb_we) r_rf[r_wb_rnum] <= r_wb_data;
  end

  // ---------------- outputs (registered state only) ----------------
  logic w_in_wb;
  assign w_in_wb = (r_state == S_WB);

  always_comb begin
    inst_req       = (r_state == S_IF);
    data_req       = (r_state == S_MEM);
    halted         = (r_state == S_HALT);
    debug_wb_valid = w_in_wb;
    debug_wb_pc    = w_in_wb ? r_pc : 32'd0;
    debug_wb_we    = w_in_wb && r_wb_we;
    debug_wb_rnum  = w_in_wb ? r_wb_rnum : 5'd0;
    debug_wb_wdata = w_in_wb ? r_wb_data : 32'd0;
  end

  assign inst_addr  = r_pc;
  assign data_we    = r_mem_we;
  assign data_addr  = r_mem_addr;
  assign data_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/minicpu_mc.md
# minicpu_mc

Multi-cycle successor to the single-cycle miniCPU core: executes a LoongArch32 integer subset through an IF/EX/MEM/WB state machine over variable-latency req/ack instruction and data ports. It tolerates any memory wait-state count and has a wider instruction set (sub.w, beq, b, bl). It offers a selectable illegal-instruction trap and a writeback trace port for the difftest bench. It sits between the SoC SRAM controllers and the top-level wrapper.

## Interface
- RESET_PC, 32'h1c000000, PC loaded on reset
- TRAP_ON_ILLEGAL, 0, 1: undecoded instruction halts core; 0: executes as NOP
- clk  input  1  core clock
- resetn  input  1  asynchronous, active-low reset; one clock domain
- inst_req  output  1  instruction fetch request, held until inst_ack
- inst_addr  output  32  fetch address (= pc), stable while inst_req
- inst_ack  input  1  fetch complete; inst_rdata valid this cycle
- inst_rdata  input  32  fetched instruction
- data_req  output  1  data access request, held until data_ack
- data_we  output  1  1 = store, 0 = load; stable while data_req
- data_addr  output  32  rj + sext(si12)
- data_wdata  output  32  rd value (stores)
- data_ack  input  1  access complete; data_rdata valid this cycle for loads
- data_rdata  input  32  load data
- halted  output  1  core stopped on illegal instruction (TRAP_ON_ILLEGAL=1)
- debug_wb_valid  output  1  one-cycle pulse per retired instruction
- debug_wb_pc  output  32  PC of retired instruction
- debug_wb_we  output  1  register write performed (rd != 0)
- debug_wb_rnum  output  5  destination register
- debug_wb_wdata  output  32  value written

## Operation
- States: BOOT, IF, EX, MEM, WB, HALT. Reset forces BOOT; BOOT -> IF unconditionally.
- IF: inst_req=1, inst_addr=pc. On inst_ack, latch inst_rdata into IR and go to EX.
- EX: decode IR and read the regfile (rj; rk, or rd for st/beq/bne). Register alu_result, store data, next_pc and the writeback fields.
  - ld.w/st.w -> MEM.
  - Illegal with TRAP_ON_ILLEGAL=1 -> HALT.
  - Otherwise -> WB.
- MEM: data_req=1. On data_ack go to WB; for ld.w, latch data_rdata as the writeback value.
- WB: write regfile if gr_we and rd != 0; pc <= next_pc; pulse debug_wb_valid; -> IF.
- HALT: terminal. halted=1, no requests. Exit only by reset.
- Decode fields:
  - add.w: inst[31:15]=17'h00020. sub.w: 17'h00022.
  - addi.w: inst[31:22]=10'h00a. ld.w: 10'h0a2. st.w: 10'h0a6.
  - beq: inst[31:26]=6'h16. bne: 6'h17. b: 6'h14. bl: 6'h15.
- Immediates:
  - si12 = sext(inst[21:10]).
  - Branch offset = sext({inst[25:10],2'b0}).
  - b/bl offset = sext({inst[9:0],inst[25:10],2'b0}).
- Branch and jump:
  - beq/bne target = pc + offset when taken, else pc+4.
  - b/bl always jump.
  - bl writes r1 <= pc+4.
- Writes:
  - Writes to r0 are discarded, and debug_wb_we=0 for them.
  - r0 always reads 0.
  - Arithmetic is 32-bit modulo; no overflow detection.
- Illegal instruction with TRAP_ON_ILLEGAL=0: retires as NOP (pc+4, debug_wb_we=0).
- Regfile contents are not reset.

## Timing
- Reset values:
  - pc=RESET_PC; state=BOOT.
  - All outputs 0 except inst_addr=RESET_PC; all debug outputs 0.
- inst_req/data_req are decoded from registered state only; no input -> output combinational path.
- Ack may arrive in the first request cycle (zero wait).
- Ack while the matching req=0 is ignored.
- Minimum CPI:
  - Non-memory instructions: 3 (IF, EX, WB).
  - ld.w/st.w: 4.
  - Each wait cycle adds 1.
- First inst_req is asserted in the 2nd rising edge after resetn deasserts (BOOT cycle first).
- Register write and pc update take effect at the WB edge; the next IF sees the new pc.
- debug_wb_* are valid only while debug_wb_valid=1 (the WB cycle).
- resetn asserted mid-transaction: requests drop asynchronously, the in-flight access is abandoned, and a late ack is ignored.

## Test plan
- Reset release with inst_ack tied 1:
  - inst_addr=32'h1c000000, inst_req first high in cycle 2.
  - addi.w r1,r0,5 retires with debug_wb_rnum=1, debug_wb_wdata=5, three cycles per instruction.
- add.w/sub.w with r1=5, r2=7:
  - sub.w r3,r1,r2 writes 32'hfffffffe.
  - add.w r0,r1,r2 gives debug_wb_we=0 and r0 still reads 0.
- Memory with 3-cycle data latency:
  - st.w r2,r1,8 holds data_req/data_addr=13/data_wdata=7 for all wait cycles.
  - ld.w r4,r1,8 then writes 7.
- Branches:
  - bne r1,r2,-8 taken -> next inst_addr = pc-8.
  - beq not taken -> pc+4.
  - bl +16 writes r1=pc+4 and jumps to pc+16.
- Illegal 32'hffffffff:
  - TRAP_ON_ILLEGAL=0: retires as NOP with pc+4.
  - TRAP_ON_ILLEGAL=1: halted=1, no further requests, until reset.
- Reset mid-fetch: assert resetn=0 during a stalled inst_req.
  - inst_req drops immediately.
  - A stray inst_ack is ignored.
  - After release the core refetches from 32'h1c000000.
